// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, data width, and the state enumeration
// of the iterative multiplier that drives the ALU as an initiator.
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Multiplier sequencing states. The ABS/NEG/FIX states are only reached
  // when the signed extension is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_MUL    = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_FIX_HI = 3'd6,
    ST_DONE   = 3'd7
  } mul_state_e;

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU. CarryOut is the carry for ADD and the
// unsigned borrow (A < B) for SUB; it is zero for the logic ops.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALUop,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  CarryOut
);

  // Operation select; every output gets a default first.
  always_comb begin
    Result   = '0;
    CarryOut = 1'b0;
    case (ALUop)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_ADD: {CarryOut, Result} = {1'b0, A} + {1'b0, B};
      ALU_SUB: begin
        Result   = A - B;
        CarryOut = (A < B);
      end
      ALU_SLT: Result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_iter.sv
// Iterative 32x32 -> 64 shift-add multiplier that borrows an external
// combinational ALU for every addition/subtraction it needs.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; valid never depends combinationally on ready. Only one
// request is in flight: in_ready is high only in IDLE, and the product is
// held in DONE until it is taken.
//
// Optional feature macro: MUL_SIGNED_EN adds the in_signed port and the
// ABS_A/ABS_B/NEG_LO/NEG_HI/FIX_HI states for two's complement operands.
// Without it the block is unsigned only.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
`ifdef MUL_SIGNED_EN
  input  logic                    in_signed,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_product,
  output logic [DATA_WIDTH-1:0]   alu_A,
  output logic [DATA_WIDTH-1:0]   alu_B,
  output logic [2:0]              alu_ALUop,
  input  logic [DATA_WIDTH-1:0]   alu_Result,
  input  logic                    alu_CarryOut,
  output mul_state_e              dbg_state
);

  // The MUL state spends ITER cycles iterating, then one cycle with the
  // counter at ITER before leaving; this gives the 33-cycle latency.
  localparam logic [5:0] ITER_LAST = 6'(ITER);

  mul_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] p_hi;
  logic [DATA_WIDTH-1:0] p_lo;
  logic [5:0]            cnt;
`ifdef MUL_SIGNED_EN
  logic                  signed_op;
  logic                  neg;
  logic                  borrow;
`endif

  assign dbg_state   = state;
  assign out_product = (state == ST_DONE) ? {p_hi, p_lo} : '0;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus all combinational outputs, including the ALU request.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = ALU_AND;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef MUL_SIGNED_EN
          state_nxt = in_signed ? ST_ABS_A : ST_MUL;
`else
          state_nxt = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        if (cnt < ITER_LAST) begin
          alu_A     = p_hi;
          alu_B     = p_lo[0] ? mcand : '0;
          alu_ALUop = ALU_ADD;
        end else begin
`ifdef MUL_SIGNED_EN
          state_nxt = signed_op ? ST_NEG_LO : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      ST_ABS_A: begin
        if (mcand[DATA_WIDTH-1]) begin
          alu_B     = mcand;
          alu_ALUop = ALU_SUB;
        end
        state_nxt = ST_ABS_B;
      end
      ST_ABS_B: begin
        if (p_lo[DATA_WIDTH-1]) begin
          alu_B     = p_lo;
          alu_ALUop = ALU_SUB;
        end
        state_nxt = ST_MUL;
      end
      ST_NEG_LO: begin
        if (neg) begin
          alu_B     = p_lo;
          alu_ALUop = ALU_SUB;
        end
        state_nxt = ST_NEG_HI;
      end
      ST_NEG_HI: begin
        if (neg) begin
          alu_B     = p_hi;
          alu_ALUop = ALU_SUB;
        end
        state_nxt = ST_FIX_HI;
      end
      ST_FIX_HI: begin
        // Propagate the borrow out of the low word into the negated high word.
        if (neg && borrow) begin
          alu_A     = p_hi;
          alu_B     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
          alu_ALUop = ALU_SUB;
        end
        state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand/product shift register; it captures the ALU result each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      cnt       <= '0;
`ifdef MUL_SIGNED_EN
      signed_op <= 1'b0;
      neg       <= 1'b0;
      borrow    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand     <= in_a;
            p_lo      <= in_b;
            p_hi      <= '0;
            cnt       <= '0;
`ifdef MUL_SIGNED_EN
            signed_op <= in_signed;
            neg       <= in_signed & (in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1]);
            borrow    <= 1'b0;
`endif
          end
        end
        ST_MUL: begin
          if (cnt < ITER_LAST) begin
            // The 33-bit sum enters the top while the multiplier shifts out.
            {p_hi, p_lo} <= {alu_CarryOut, alu_Result, p_lo[DATA_WIDTH-1:1]};
            cnt          <= cnt + 6'd1;
          end
        end
`ifdef MUL_SIGNED_EN
        ST_ABS_A:  if (mcand[DATA_WIDTH-1]) mcand <= alu_Result;
        ST_ABS_B:  if (p_lo[DATA_WIDTH-1])  p_lo  <= alu_Result;
        ST_NEG_LO: begin
          if (neg) begin
            p_lo   <= alu_Result;
            borrow <= alu_CarryOut;
          end
        end
        ST_NEG_HI: if (neg)           p_hi <= alu_Result;
        ST_FIX_HI: if (neg && borrow) p_hi <= alu_Result;
`endif
        default: ;
      endcase
    end
  end

endmodule
